coef_load_ctrl: RTL and testbench
=================================

COEF_LOAD_CTRL -- requirements
Module: coef_load_ctrl

Interface
REQ-001 Parameters (name, default, meaning): NUM_BANKS, 4, coefficient banks (cos_1, sin_1, cos_2, sin_2); NUM_TAPS, 8, entries per bank; COEF_W, 5, coefficient width.
REQ-002 Ports (name, direction, width, meaning):
- SCLK, in, 1: single clock, free-running, all logic on posedge.
- reset, in, 1: asynchronous, active-low.
- cs_n, in, 1: frame select, active-low.
- MOSI, in, 1: serial data, MSB first.
- wr_en, out, 1: coefficient write strobe.
- wr_bank, out, 2: bank select.
- wr_idx, out, 3: tap index.
- wr_data, out, COEF_W: coefficient value.
- apply_req, out, 1: request to swap the shadow coefficients into the active set.
- apply_ack, in, 1: modulator accepts the swap.
- busy, out, 1: clear sweep or apply pending.
- frame_err, out, 1: sticky error flag.

Function
REQ-003 The frame SHALL be 16 bits: [15:14] opcode (00 NOP, 01 WRITE, 10 APPLY, 11 CLEAR), [13:12] bank, [11:9] idx, [8:5] reserved (ignored), [4:0] data.
REQ-004 The FSM SHALL have states IDLE, SHIFT, EXEC, HOLD, CLEAR, APPLY.
REQ-005 IDLE to SHIFT on the first edge with cs_n=0. That edge samples frame bit 15 and sets the bit counter to 1.
REQ-006 SHIFT: shift MOSI in on each edge with cs_n=0. The edge capturing the 16th bit moves to EXEC.
REQ-007 cs_n=1 in SHIFT with fewer than 16 bits: discard the frame, set frame_err, go to IDLE, issue no write.
REQ-008 EXEC lasts one cycle and executes the captured frame. Latency is 1 cycle from the 16th bit to wr_en or apply_req. EXEC then goes to HOLD, CLEAR or APPLY.
REQ-009 WRITE: wr_en=1 for exactly one cycle, with wr_bank, wr_idx and wr_data taken from the frame.
REQ-010 NOP: no output change.
REQ-011 CLEAR: enter CLEAR and sweep 32 consecutive cycles.
- wr_en=1 every sweep cycle, wr_data=0.
- {wr_bank, wr_idx} runs 0 to 31 (bank 0 idx 0 first, idx increments fastest).
- busy=1 throughout.
REQ-012 APPLY: assert apply_req and busy, held until the first cycle with apply_ack=1. apply_req and busy fall on the next edge; the FSM returns to HOLD or IDLE.
REQ-013 apply_ack with apply_req=0 SHALL be ignored.
REQ-014 HOLD: ignore further bits until cs_n=1, then IDLE.
REQ-015 After CLEAR or APPLY completes: go to HOLD if cs_n=0, else IDLE.
REQ-016 cs_n=0 while busy=1: the frame SHALL be ignored and frame_err set. The CLEAR sweep or apply handshake SHALL complete unaffected.
REQ-017 wr_en SHALL be 0 in every state except EXEC (WRITE) and CLEAR.
REQ-018 wr_bank, wr_idx and wr_data SHALL hold their last values when wr_en=0.
REQ-019 frame_err SHALL be cleared only by reset or by the EXEC of a valid NOP frame.

Reset
REQ-020 reset=0 SHALL asynchronously force:
- state IDLE, shift register 0, bit counter 0;
- wr_en=0, wr_bank=0, wr_idx=0, wr_data=0;
- apply_req=0, busy=0, frame_err=0.
REQ-021 Reset mid-frame, mid-sweep or mid-handshake SHALL abandon the operation with no further writes. Release is synchronous to the next SCLK edge.

Verification
REQ-022 WRITE frame 0x5A13 (opcode 01, bank 01, idx 101, data 10011), cs_n held low -> one cycle after the 16th bit: wr_en=1 for 1 cycle, wr_bank=1, wr_idx=5, wr_data=0x13. No further strobe until cs_n rises.
REQ-023 CLEAR frame 0xC000 -> exactly 32 wr_en cycles, addresses 0 to 31, data 0, busy=1 for 32 cycles then 0.
REQ-024 APPLY frame 0x8000, apply_ack raised 5 cycles later -> apply_req=1 and busy=1 from the cycle after the 16th bit until the edge after ack, then both 0. No wr_en pulses.
REQ-025 cs_n rises after 9 bits -> frame_err=1 and no wr_en. A following NOP frame 0x0000 -> frame_err=0.
REQ-026 A WRITE frame sent during a CLEAR sweep -> ignored, frame_err=1, and the sweep still produces 32 zero writes.
REQ-027 reset=0 asserted at sweep cycle 10 -> all outputs 0 immediately. After release, a new WRITE frame executes normally.

Source files
------------

// File: rtl/coef_load_ctrl.sv
// Serial coefficient loader: receives 16-bit frames on cs_n/MOSI and turns them into
// coefficient writes, a 32-entry clear sweep, or an apply handshake with the modulator.
module coef_load_ctrl #(
  parameter int NUM_BANKS = 4,
  parameter int NUM_TAPS  = 8,
  parameter int COEF_W    = 5
) (
  input  logic              SCLK,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              MOSI,
  output logic              wr_en,
  output logic [1:0]        wr_bank,
  output logic [2:0]        wr_idx,
  output logic [COEF_W-1:0] wr_data,
  output logic              apply_req,
  input  logic              apply_ack,
  output logic              busy,
  output logic              frame_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_EXEC  = 3'd2,
    S_HOLD  = 3'd3,
    S_CLEAR = 3'd4,
    S_APPLY = 3'd5
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_APPLY = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam logic [4:0] CLR_LAST = 5'(NUM_BANKS * NUM_TAPS - 1);

  state_t              r_state;
  logic [14:0]         r_shift;
  logic [4:0]          r_cnt;
  logic [1:0]          r_op;
  logic                r_cs_d;
  logic                r_wr_en;
  logic [1:0]          r_wr_bank;
  logic [2:0]          r_wr_idx;
  logic [COEF_W-1:0]   r_wr_data;
  logic                r_apply_req;
  logic                r_busy;
  logic                r_frame_err;

  logic                w_new_frame;
  state_t              w_done_state;

  // A frame start is a falling cs_n; only a fresh frame during busy counts as an error.
  assign w_new_frame  = r_cs_d & ~cs_n;
  assign w_done_state = cs_n ? S_IDLE : S_HOLD;

  assign wr_en     = r_wr_en;
  assign wr_bank   = r_wr_bank;
  assign wr_idx    = r_wr_idx;
  assign wr_data   = r_wr_data;
  assign apply_req = r_apply_req;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;

  // Frame receiver, command execution and all registered outputs.
  always_ff @(posedge SCLK or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_shift     <= 15'd0;
      r_cnt       <= 5'd0;
      r_op        <= OP_NOP;
      r_cs_d      <= 1'b1;
      r_wr_en     <= 1'b0;
      r_wr_bank   <= 2'd0;
      r_wr_idx    <= 3'd0;
      r_wr_data   <= '0;
      r_apply_req <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cs_d <= cs_n;
      case (r_state)
        S_IDLE: begin
          if (!cs_n) begin
            r_shift <= {14'd0, MOSI};
            r_cnt   <= 5'd1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cs_n) begin
            r_frame_err <= 1'b1;
            r_cnt       <= 5'd0;
            r_shift     <= 15'd0;
            r_state     <= S_IDLE;
          end else begin
            r_shift <= {r_shift[13:0], MOSI};
            r_cnt   <= r_cnt + 5'd1;
            if (r_cnt == 5'd15) begin
              // r_shift holds frame bits 15..1 here; MOSI is bit 0.
              r_op    <= r_shift[14:13];
              r_cnt   <= 5'd0;
              r_state <= S_EXEC;
              if (r_shift[14:13] == OP_WRITE) begin
                r_wr_en   <= 1'b1;
                r_wr_bank <= r_shift[12:11];
                r_wr_idx  <= r_shift[10:8];
                r_wr_data <= COEF_W'({r_shift[3:0], MOSI});
              end else if (r_shift[14:13] == OP_APPLY) begin
                r_apply_req <= 1'b1;
                r_busy      <= 1'b1;
              end else begin
                r_wr_en <= 1'b0;
              end
            end
          end
        end
        S_EXEC: begin
          r_wr_en <= 1'b0;
          case (r_op)
            OP_NOP: begin
              r_frame_err <= 1'b0;
              r_state     <= S_HOLD;
            end
            OP_WRITE: r_state <= S_HOLD;
            OP_CLEAR: begin
              r_wr_en   <= 1'b1;
              r_wr_bank <= 2'd0;
              r_wr_idx  <= 3'd0;
              r_wr_data <= '0;
              r_busy    <= 1'b1;
              r_state   <= S_CLEAR;
            end
            OP_APPLY: begin
              if (apply_ack) begin
                r_apply_req <= 1'b0;
                r_busy      <= 1'b0;
                r_state     <= w_done_state;
              end else begin
                r_state <= S_APPLY;
              end
            end
            default: r_state <= S_HOLD;
          endcase
        end
        S_HOLD: begin
          if (cs_n) begin
            r_state <= S_IDLE;
          end
        end
        S_CLEAR: begin
          if (w_new_frame) begin
            r_frame_err <= 1'b1;
          end
          if ({r_wr_bank, r_wr_idx} == CLR_LAST) begin
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= w_done_state;
          end else begin
            {r_wr_bank, r_wr_idx} <= {r_wr_bank, r_wr_idx} + 5'd1;
          end
        end
        S_APPLY: begin
          if (w_new_frame) begin
            r_frame_err <= 1'b1;
          end
          if (apply_ack) begin
            r_apply_req <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= w_done_state;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coef_load_ctrl.sv
// Directed self-checking bench for coef_load_ctrl: inputs driven on the falling edge,
// outputs sampled on the falling edge after each rising edge.
module tb_coef_load_ctrl;

  logic       SCLK;
  logic       reset;
  logic       cs_n;
  logic       MOSI;
  logic       wr_en;
  logic [1:0] wr_bank;
  logic [2:0] wr_idx;
  logic [4:0] wr_data;
  logic       apply_req;
  logic       apply_ack;
  logic       busy;
  logic       frame_err;

  int n_tests = 0;
  int n_fail  = 0;

  coef_load_ctrl #(.NUM_BANKS(4), .NUM_TAPS(8), .COEF_W(5)) dut (
    .SCLK      (SCLK),
    .reset     (reset),
    .cs_n      (cs_n),
    .MOSI      (MOSI),
    .wr_en     (wr_en),
    .wr_bank   (wr_bank),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .apply_req (apply_req),
    .apply_ack (apply_ack),
    .busy      (busy),
    .frame_err (frame_err)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  task automatic send_frame(input logic [15:0] f);
    for (int i = 15; i >= 0; i--) begin
      @(negedge SCLK);
      cs_n = 1'b0;
      MOSI = f[i];
    end
  endtask

  task automatic test_reset();
    logic [14:0] outs;
    reset = 1'b0; cs_n = 1'b1; MOSI = 1'b0; apply_ack = 1'b0;
    @(negedge SCLK);
    outs = {wr_en, wr_bank, wr_idx, wr_data, apply_req, busy, frame_err};
    n_tests++;
    if (outs !== 15'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    @(negedge SCLK);
    reset = 1'b1;
    apply_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge SCLK);
      n_tests++;
      if ({apply_req, busy, wr_en} !== 3'b000) begin
        n_fail++; $display("FAIL stray_ack: got %b want 000", {apply_req, busy, wr_en});
      end
    end
    apply_ack = 1'b0;
  endtask

  task automatic test_write();
    int extra = 0;
    send_frame(16'h5A13);
    @(negedge SCLK);
    n_tests++;
    if ({wr_en, wr_bank, wr_idx, wr_data} !== {1'b1, 2'd1, 3'd5, 5'h13}) begin
      n_fail++;
      $display("FAIL write_strobe: got en=%b bank=%0d idx=%0d data=%h want en=1 bank=1 idx=5 data=13",
               wr_en, wr_bank, wr_idx, wr_data);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge SCLK);
      if (wr_en) extra++;
    end
    cs_n = 1'b1;
    repeat (2) @(negedge SCLK);
    n_tests++;
    if (extra !== 0) begin
      n_fail++; $display("FAIL write_single: got %0d extra strobes want 0", extra);
    end
    n_tests++;
    if ({wr_bank, wr_idx, wr_data} !== {2'd1, 3'd5, 5'h13}) begin
      n_fail++; $display("FAIL write_hold: got %h want %h", {wr_bank, wr_idx, wr_data}, {2'd1, 3'd5, 5'h13});
    end
  endtask

  task automatic test_clear();
    int n_wr = 0, n_busy = 0, bad = 0, first = -1;
    send_frame(16'hC000);
    @(negedge SCLK);
    cs_n = 1'b1;
    n_tests++;
    if (wr_en !== 1'b0) begin
      n_fail++; $display("FAIL clear_exec_no_write: got %b want 0", wr_en);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge SCLK);
      if (busy) n_busy++;
      if (wr_en) begin
        if (first < 0) first = i;
        if ({wr_bank, wr_idx} !== 5'(n_wr) || wr_data !== 5'd0) bad++;
        n_wr++;
      end
    end
    n_tests++;
    if (n_wr !== 32) begin
      n_fail++; $display("FAIL clear_count: got %0d writes want 32", n_wr);
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL clear_addr_data: got %0d bad writes want 0", bad);
    end
    n_tests++;
    if (n_busy !== 32 || busy !== 1'b0) begin
      n_fail++; $display("FAIL clear_busy: got %0d busy cycles end=%b want 32 end=0", n_busy, busy);
    end
    n_tests++;
    if (first !== 0) begin
      n_fail++; $display("FAIL clear_start: got first write at %0d want 0", first);
    end
  endtask

  task automatic test_apply();
    int n_req = 0, n_wr = 0;
    send_frame(16'h8000);
    @(negedge SCLK);
    cs_n = 1'b1;
    n_tests++;
    if ({apply_req, busy} !== 2'b11) begin
      n_fail++; $display("FAIL apply_start: got %b want 11", {apply_req, busy});
    end
    for (int c = 2; c < 12; c++) begin
      @(negedge SCLK);
      if (apply_req && busy) n_req++;
      if (wr_en) n_wr++;
      if (c == 5) apply_ack = 1'b1;
      if (c == 6) begin
        apply_ack = 1'b0;
        n_tests++;
        if ({apply_req, busy} !== 2'b00) begin
          n_fail++; $display("FAIL apply_drop: got %b want 00", {apply_req, busy});
        end
      end
    end
    n_tests++;
    if (n_req !== 4) begin
      n_fail++; $display("FAIL apply_hold: got %0d cycles want 4", n_req);
    end
    n_tests++;
    if (n_wr !== 0) begin
      n_fail++; $display("FAIL apply_no_write: got %0d strobes want 0", n_wr);
    end
  endtask

  task automatic test_abort();
    logic [15:0] f;
    int n_wr = 0;
    f = 16'h5A13;
    for (int i = 15; i >= 7; i--) begin
      @(negedge SCLK);
      cs_n = 1'b0;
      MOSI = f[i];
    end
    @(negedge SCLK);
    cs_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge SCLK);
      if (wr_en) n_wr++;
    end
    n_tests++;
    if (frame_err !== 1'b1 || n_wr !== 0) begin
      n_fail++; $display("FAIL abort: got err=%b writes=%0d want err=1 writes=0", frame_err, n_wr);
    end
    send_frame(16'h0000);
    @(negedge SCLK);
    cs_n = 1'b1;
    n_tests++;
    if (frame_err !== 1'b1) begin
      n_fail++; $display("FAIL nop_exec_err: got %b want 1", frame_err);
    end
    @(negedge SCLK);
    n_tests++;
    if (frame_err !== 1'b0 || wr_en !== 1'b0) begin
      n_fail++; $display("FAIL nop_clears_err: got err=%b en=%b want 0 0", frame_err, wr_en);
    end
  endtask

  task automatic test_busy_frame();
    int n_wr = 0, bad = 0;
    send_frame(16'hC000);
    @(negedge SCLK);
    cs_n = 1'b1;
    fork
      begin
        repeat (2) @(negedge SCLK);
        send_frame(16'h5A13);
        @(negedge SCLK);
        cs_n = 1'b1;
      end
      begin
        for (int i = 0; i < 45; i++) begin
          @(negedge SCLK);
          if (wr_en) begin
            if ({wr_bank, wr_idx} !== 5'(n_wr) || wr_data !== 5'd0) bad++;
            n_wr++;
          end
        end
      end
    join
    n_tests++;
    if (n_wr !== 32 || bad !== 0) begin
      n_fail++; $display("FAIL busy_sweep: got %0d writes %0d bad want 32 0", n_wr, bad);
    end
    n_tests++;
    if (frame_err !== 1'b1) begin
      n_fail++; $display("FAIL busy_err: got %b want 1", frame_err);
    end
    n_tests++;
    if ({wr_bank, wr_idx} !== 5'd31) begin
      n_fail++; $display("FAIL busy_ignored: got addr %0d want 31", {wr_bank, wr_idx});
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [14:0] outs;
    int n_wr = 0;
    bit found = 1'b0;
    send_frame(16'hC000);
    @(negedge SCLK);
    cs_n = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge SCLK);
      if (wr_en && {wr_bank, wr_idx} == 5'd10) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL sweep_reach10: got not reached want reached");
    end
    #2 reset = 1'b0;
    #1;
    outs = {wr_en, wr_bank, wr_idx, wr_data, apply_req, busy, frame_err};
    n_tests++;
    if (outs !== 15'd0) begin
      n_fail++; $display("FAIL async_reset: got %h want 0", outs);
    end
    repeat (2) @(negedge SCLK);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge SCLK);
      if (wr_en) n_wr++;
    end
    n_tests++;
    if (n_wr !== 0) begin
      n_fail++; $display("FAIL post_reset_quiet: got %0d writes want 0", n_wr);
    end
    send_frame(16'h7C0A);
    @(negedge SCLK);
    cs_n = 1'b1;
    n_tests++;
    if ({wr_en, wr_bank, wr_idx, wr_data} !== {1'b1, 2'd3, 3'd6, 5'h0A}) begin
      n_fail++;
      $display("FAIL post_reset_write: got en=%b bank=%0d idx=%0d data=%h want en=1 bank=3 idx=6 data=0a",
               wr_en, wr_bank, wr_idx, wr_data);
    end
    repeat (2) @(negedge SCLK);
  endtask

  initial begin
    test_reset();
    test_write();
    test_clear();
    test_apply();
    test_abort();
    test_busy_frame();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
